// File: rtl/theta_pkg.sv
// Shared constants, GF(2^8) helpers and FSM encoding for the theta diffusion stages.
package theta_pkg;

    // Low byte of the reduction polynomial x^8 + x^4 + x^3 + x^2 + 1 (0x11d)
    localparam logic [7:0] GF_RED = 8'h1d;

    // Column-map coefficients
    localparam logic [2:0] COEF_1 = 3'd1;
    localparam logic [2:0] COEF_2 = 3'd2;
    localparam logic [2:0] COEF_4 = 3'd4;
    localparam logic [2:0] COEF_6 = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x in GF(2^8), reducing modulo 0x11d
    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
    endfunction

    // Multiply by one of the column-map coefficients
    function automatic logic [7:0] gf_scale(input logic [7:0] x, input logic [2:0] coef);
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = gf_xtime(x);
        x4 = gf_xtime(x2);
        case (coef)
            COEF_1:  return x;
            COEF_2:  return x2;
            COEF_4:  return x4;
            COEF_6:  return x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/theta_col.sv
// Combinational 32-bit theta column map; self-inverse, so shared by the
// forward and inverse diffusion stages. Byte a1 is the MSB byte.
module theta_col
    import theta_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] b
);

    logic [7:0] a1, a2, a3, a4;

    assign a1 = a[31:24];
    assign a2 = a[23:16];
    assign a3 = a[15:8];
    assign a4 = a[7:0];

    assign b[31:24] = gf_scale(a1, COEF_1) ^ gf_scale(a2, COEF_2) ^ gf_scale(a3, COEF_4) ^ gf_scale(a4, COEF_6);
    assign b[23:16] = gf_scale(a1, COEF_2) ^ gf_scale(a2, COEF_1) ^ gf_scale(a3, COEF_6) ^ gf_scale(a4, COEF_4);
    assign b[15:8]  = gf_scale(a1, COEF_4) ^ gf_scale(a2, COEF_6) ^ gf_scale(a3, COEF_1) ^ gf_scale(a4, COEF_2);
    assign b[7:0]   = gf_scale(a1, COEF_6) ^ gf_scale(a2, COEF_4) ^ gf_scale(a3, COEF_2) ^ gf_scale(a4, COEF_1);

endmodule

// File: rtl/inv_theta_serial.sv
// Column-serial inverse theta: loads a 128-bit state, rewrites one column per
// cycle from [31:0] upward, then holds the result until downstream takes it.
module inv_theta_serial
    import theta_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         busy
);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic         accept;

    assign accept = s_valid && s_ready;
    assign m_data = work;

    // Select the column currently being diffused
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        col_in = work[31:0];
        case (cnt)
            2'd0: col_in = work[31:0];
            2'd1: col_in = work[63:32];
            2'd2: col_in = work[95:64];
            2'd3: col_in = work[127:96];
            default: col_in = work[31:0];
        endcase
    end

    theta_col u_col (
        .a (col_in),
        .b (col_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s_valid) state_nxt = RUN;
            RUN:  if (cnt == 2'd3) state_nxt = DONE;
            DONE: if (m_ready) state_nxt = s_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state (DONE passes m_ready through)
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE: s_ready = 1'b1;
            RUN:  busy    = 1'b1;
            DONE: begin
                s_ready = m_ready;
                m_valid = 1'b1;
                busy    = 1'b1;
            end
            default: s_ready = 1'b0;
        endcase
    end

    // Work register and column counter: load on accept, rewrite one column per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= 2'd0;
        end else if (state == RUN) begin
            case (cnt)
                2'd0: work[31:0]   <= col_out;
                2'd1: work[63:32]  <= col_out;
                2'd2: work[95:64]  <= col_out;
                2'd3: work[127:96] <= col_out;
                default: work[31:0] <= col_out;
            endcase
            cnt <= cnt + 2'd1;
        end else if (accept) begin
            work <= s_data;
            cnt  <= 2'd0;
        end
    end

endmodule

// File: tb/tb_inv_theta_serial.sv
// Self-checking bench for inv_theta_serial: scoreboard queue filled on accept,
// drained by a monitor on the falling edge, reference model uses generic GF math.
module tb_inv_theta_serial;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [127:0] exp_q[$];

    // Period monitoring for the back-to-back test
    bit b2b_mode  = 0;
    int last_rise = -1;
    bit mv_prev   = 0;

    inv_theta_serial dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    // Generic shift-and-add GF(2^8) multiply, poly 0x11d
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] model_col(input logic [31:0] c);
        logic [7:0] coef [4][4] = '{'{8'd1, 8'd2, 8'd4, 8'd6},
                                    '{8'd2, 8'd1, 8'd6, 8'd4},
                                    '{8'd4, 8'd6, 8'd1, 8'd2},
                                    '{8'd6, 8'd4, 8'd2, 8'd1}};
        logic [7:0] a [4];
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gf_mul(coef[row][k], a[k]);
            r[31 - 8*row -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) r[32*c +: 32] = model_col(s[32*c +: 32]);
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on each output transfer; track m_valid rise spacing
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 128'd1, 128'd0);
                else check("m_data", m_data, exp_q.pop_front());
            end
            if (m_valid && !mv_prev) begin
                if (b2b_mode && last_rise >= 0)
                    check("b2b_period", 128'(cyc - last_rise), 128'd5);
                last_rise = cyc;
            end
        end
        mv_prev = m_valid;
    end

    // ---------------- stimulus ----------------
    // Called at posedge+#1; returns at posedge+#1 after the accept edge
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit keep);
        int k = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!s_ready) check("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] x, y;
        logic [127:0] lat_vec [3];
        int k;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #12;
        check("rst_s_ready", 128'(s_ready), 128'd1);
        check("rst_m_valid", 128'(m_valid), 128'd0);
        check("rst_m_data",  m_data,        128'd0);
        check("rst_busy",    128'(busy),    128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-derived expectations
        send(128'h00000000_00000000_00000000_01000000, 128'h00000000_00000000_00000000_01020406, 0);
        send(128'h80000000_00000000_00000000_00000000, 128'h801d3a27_00000000_00000000_00000000, 0);
        send(128'h00000000_00000000_00000000_01020406, 128'h00000000_00000000_00000000_01000000, 0);
        drain();

        // Latency from accept edge to m_valid rise
        lat_vec[0] = '0;
        lat_vec[1] = {128{1'b1}};
        lat_vec[2] = {16{8'h55, 8'haa}};
        for (int i = 0; i < 3; i++) begin
            send(lat_vec[i], model_state(lat_vec[i]), 0);
            check("busy_in_run", 128'(busy), 128'd1);
            k = 0;
            while (!m_valid && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            check("latency", 128'(k), 128'd4);
            drain();
        end

        // Stall: m_ready low for 10 cycles, s_data wiggles and must be ignored
        m_ready = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom};
        y = model_state(x);
        send(x, y, 0);
        k = 0;
        while (!m_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_m_data",  m_data,           y);
            check("stall_s_ready", 128'(s_ready),    128'd0);
            check("stall_m_valid", 128'(m_valid),    128'd1);
            @(posedge clk); #1;
            s_data = {$urandom, $urandom, $urandom, $urandom};
        end
        m_ready = 1'b1;
        drain();

        // Back-to-back with both valids high
        b2b_mode  = 1;
        last_rise = -1;
        for (int i = 0; i < 6; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            send(x, model_state(x), 1);
        end
        s_valid = 1'b0;
        drain();
        b2b_mode = 0;

        // Reset in the middle of RUN discards the block
        x = {$urandom, $urandom, $urandom, $urandom};
        send(x, model_state(x), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_m_valid", 128'(m_valid), 128'd0);
        check("midrst_s_ready", 128'(s_ready), 128'd1);
        check("midrst_m_data",  m_data,        128'd0);
        check("midrst_busy",    128'(busy),    128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        x = {$urandom, $urandom, $urandom, $urandom};
        send(x, model_state(x), 0);
        drain();

        // Random involution sweep: x -> H(x), then H(x) -> x (1000 states)
        for (int i = 0; i < 500; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = model_state(x);
            send(x, y, 0);
            send(y, x, 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

endmodule

// File: doc/inv_theta_serial.md
# inv_theta_serial

Column-serial inverse theta diffusion for the decryption datapath of the 128-bit block cipher. It accepts a 128-bit state over a valid/ready handshake and applies the inverse of the theta column map in GF(2^8), reduction polynomial 0x11d, one 32-bit column per cycle. It returns the diffused state over a second valid/ready handshake. It sits between the inverse key-addition stage and the inverse substitution stage.

## Interface
- No parameters; all widths are fixed by the cipher.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input state valid
- s_ready  out  1  block can accept an input state
- s_data  in  128  input state; 4 columns at [127:96], [95:64], [63:32], [31:0]; byte a1 of a column is its MSB byte, a4 its LSB byte
- m_valid  out  1  output state valid
- m_ready  in  1  downstream accepts the output state
- m_data  out  128  diffused state, same layout as s_data
- busy  out  1  a state is held (RUN or DONE)

## Operation
- Column map H over GF(2^8), poly 0x11d; addition is XOR and multiplication is polynomial multiplication.
  - b1 = 1·a1 ^ 2·a2 ^ 4·a3 ^ 6·a4
  - b2 = 2·a1 ^ 1·a2 ^ 6·a3 ^ 4·a4
  - b3 = 4·a1 ^ 6·a2 ^ 1·a3 ^ 2·a4
  - b4 = 6·a1 ^ 4·a2 ^ 2·a3 ^ 1·a4
- H is an involution (H·H = I), so the inverse uses the same coefficients. The implementation must use exact GF arithmetic; integer add or modulo is forbidden.
- Multiplication: xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1d : 0); 4·x = xtime(xtime(x)); 6·x = 4·x ^ 2·x.
- FSM states:
  - IDLE: s_ready = 1. On s_valid, load s_data into the 128-bit work register, clear cnt, go to RUN.
  - RUN: replace column cnt in place, in order [31:0], [63:32], [95:64], [127:96]; cnt increments. After cnt = 3, go to DONE.
  - DONE: m_valid = 1 and m_data holds stable until m_ready.
    - m_ready with s_valid: load the new state, go to RUN (back-to-back). s_ready = m_ready in DONE.
    - m_ready without s_valid: go to IDLE.
- s_data is sampled only on the accept edge. Changes to s_data during RUN or DONE are ignored.
- s_valid during RUN is not accepted (s_ready = 0).
- Reset (any state, including mid-RUN): state = IDLE, cnt = 0, work register = 0, and any partial block is discarded.
  - Output values in and after reset: s_ready = 1, m_valid = 0, m_data = 0, busy = 0.

## Timing
- Accept at edge N. Columns are written at edges N+1..N+4. m_valid rises after edge N+4, so latency is 4 cycles from accept to m_valid.
- Throughput: one state per 5 cycles with m_ready held high.
- s_ready, m_valid and busy decode from registered state only, with no combinational path from s_valid. s_ready in DONE depends combinationally on m_ready only.
- m_data is driven directly from the work register.
- m_ready held low stalls indefinitely without corrupting m_data.

## Structure
- Package theta_pkg holds:
  - reduction constant 8'h1d (poly 0x11d)
  - coefficient constants 1, 2, 4, 6
  - function gf_xtime
  - FSM state enum {IDLE, RUN, DONE}
- Sub-module theta_col: a combinational 32-to-32 column map, used by both this block and the forward diffusion stage.
- The top level holds the FSM, the 2-bit counter, the 128-bit register and the column mux/demux.

## Test plan
- Single column: s_data = 128'h00000000_00000000_00000000_01000000 → m_data = 128'h00000000_00000000_00000000_01020406.
- Reduction: column 80000000 in [127:96], others 0 → m_data[127:96] = 32'h801d3a27, all other columns 0.
- Involution: send 01020406 in [31:0], then feed the output back in → 01000000. A random 1000-state sweep must satisfy H(H(x)) = x.
- Handshake: m_ready low for 10 cycles, then high.
  - m_data stays stable and s_ready = 0 throughout.
  - Back-to-back with both valids high: m_valid rises every 5 cycles.
- Reset mid-RUN: assert rst_n low at edge N+2 → m_valid = 0, s_ready = 1, m_data = 0. The next block returns its correct result.
- Latency: check the accept edge to m_valid rise is exactly 4 cycles for states 0, all-FF and alternating 55/AA.
